mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit sequencer for the P6 pipelined MIPS core, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and owns the HI/LO registers.
- Models multi-cycle latency with a down-counter and busy flag.
- Generates the D-stage stall request that keeps MDU instructions from issuing while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles after acceptance for mult/multu (must be >= 1).
DIV_CYCLES, 10, busy cycles after acceptance for div/divu (must be >= 1).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
op_valid  input  1  E-stage instruction is an MDU operation this cycle
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
rs_data  input  32  forwarded rs operand
rt_data  input  32  forwarded rt operand
d_is_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
start  output  1  combinational; op_valid & op in 1..4 & state IDLE
busy  output  1  registered; high while an operation is in flight
stall_md  output  1  combinational; d_is_md & (start | busy)
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset: state IDLE, busy=0, counter=0, hi=0, lo=0, shadow result=0. Reset mid-operation aborts it; no HI/LO update.
- States: IDLE, RUN.
- IDLE, start=1, at the edge:
  - Latch the 64-bit result into the shadow {hi_n, lo_n}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy<=1, go to RUN.
- RUN, each edge:
  - Decrement the counter.
  - When the counter is 1 at an edge: hi<=hi_n, lo<=lo_n, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO are visible in the first cycle with busy=0.
- MTHI/MTLO: accepted only in IDLE with op_valid. The write lands at the same edge (hi<=rs_data or lo<=rs_data). start stays 0.
- op_valid while busy: ignored. The pipeline contract (stall_md) prevents it; no error flag is raised.
- Simultaneous completion edge and op_valid: the new op is ignored, because state is still RUN in that cycle.
- MULT: signed 32x32 -> 64; hi=product[63:32], lo=product[31:0].
- MULTU: the same product, unsigned.
- DIV: signed, quotient truncated toward zero -> lo; remainder takes the sign of the dividend -> hi.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient -> lo, remainder -> hi.
- Divide by zero (rt_data=0): the full DIV_CYCLES busy period still runs, but HI/LO keep their prior values at completion.
- mfhi/mflo read hi/lo directly. Correctness relies on the stall: mf* in D stalls while start|busy.

Test Plan:
1. hi=lo=0; MULT rs=0xFFFFFFFF, rt=2 -> start=1 one cycle; busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0. DIVU 7/0 -> busy 10 cycles, then hi=0x12345678, lo unchanged.
4. MULT issued with d_is_md=1 held throughout -> stall_md=1 in the start cycle and all 5 busy cycles, 0 the cycle after. With d_is_md=0 -> stall_md=0 throughout. A second MULT presented during busy is ignored; hi/lo reflect only the first.
5. Reset asserted at busy cycle 3 of a MULT -> next cycle busy=0, hi=lo=0, counter idle. A following MULT 3*4 completes normally with lo=12 after 5 busy cycles.
6. MULT completes, and MTLO rs=0xAA is presented in the first cycle with busy=0 -> lo=0xAA at the following edge, hi keeps the product high word.

Source files
------------

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO with D-stage stall request
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_n;
    logic [31:0]   lo_n;
    logic          upd;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        divisor_s;
    logic [31:0]        divisor_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [63:0]        result;
    logic               is_div;

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Divisor is forced to 1 for zero and for the signed overflow case, so the
    // dividers never see an undefined operand; overflow then yields rs / 1 = 0x80000000 rem 0.
    assign div_zero  = (rt_data == 32'd0);
    assign div_ovf   = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
    assign divisor_s = (div_zero || div_ovf) ? 32'd1 : rt_data;
    assign divisor_u = div_zero ? 32'd1 : rt_data;
    assign quot_s    = $signed(rs_data) / $signed(divisor_s);
    assign rem_s     = $signed(rs_data) % $signed(divisor_s);
    assign quot_u    = rs_data / divisor_u;
    assign rem_u     = rs_data % divisor_u;
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        result = 64'd0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quot_s};
            OP_DIVU:  result = {rem_u, quot_u};
            default:  result = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == CW'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        start    = op_valid && (op >= OP_MULT) && (op <= OP_DIVU) && (state == IDLE);
        stall_md = d_is_md && (start || busy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            hi_n <= 32'd0;
            lo_n <= 32'd0;
            upd  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                hi_n <= result[63:32];
                lo_n <= result[31:0];
                upd  <= !(is_div && div_zero);
                cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy <= 1'b1;
            end else if (op_valid && op == OP_MTHI) begin
                hi <= rs_data;
            end else if (op_valid && op == OP_MTLO) begin
                lo <= rs_data;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (upd) begin
                    hi <= hi_n;
                    lo <= lo_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard testbench for mdu_ctrl
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        d_is_md = 1'b0;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .d_is_md(d_is_md),
        .start(start), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start got %0b want 0", start); end
    endtask

    // Issues one MDU op, counts busy cycles, optionally presents a second MULT on busy cycle 'inject'.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic d, input int inject,
                          input logic [31:0] ehi, input logic [31:0] elo, input int en);
        exp_t e;
        int   n;
        bit   done;
        sb.push_back('{hi: ehi, lo: elo, n: en});
        @(negedge clk);
        d_is_md = d; op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        #1;
        n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL %s_start got %0b want 1", name, start); end
        n_cmp++; if (stall_md !== d) begin n_bad++; $display("FAIL %s_stall_start got %0b want %0b", name, stall_md, d); end
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            op_valid = 1'b0; op = 3'd0;
            if (busy) begin
                n++;
                if (inject == n) begin
                    op_valid = 1'b1; op = 3'd1; rs_data = 32'd100; rt_data = 32'd100;
                end
                #1;
                n_cmp++; if (stall_md !== d) begin n_bad++; $display("FAIL %s_stall_busy%0d got %0b want %0b", name, n, stall_md, d); end
                n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL %s_start_busy%0d got %0b want 0", name, n, start); end
            end else begin
                done = 1'b1;
            end
        end
        e = sb.pop_front();
        n_cmp++; if (!done) begin n_bad++; $display("FAIL %s_timeout busy never dropped want %0d cycles", name, e.n); end
        n_cmp++; if (n !== e.n) begin n_bad++; $display("FAIL %s_busy_len got %0d want %0d", name, n, e.n); end
        n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL %s_hi got %h want %h", name, hi, e.hi); end
        n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL %s_lo got %h want %h", name, lo, e.lo); end
        #1;
        n_cmp++; if (stall_md !== 1'b0) begin n_bad++; $display("FAIL %s_stall_after got %0b want 0", name, stall_md); end
    endtask

    task automatic test_mult();
        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    endtask

    task automatic test_div();
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("divu", 3'd4, 32'd7, 32'd2, 1'b0, 0, 32'd1, 32'd3, 10);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'h8000_0000, 10);
    endtask

    task automatic test_mthi_div0();
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5; rs_data = 32'h1234_5678; rt_data = 32'd0;
        #1;
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL mthi_start got %0b want 0", start); end
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        #1;
        n_cmp++; if (hi !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %0b want 0", busy); end
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 1'b0, 0, 32'h1234_5678, 32'h8000_0000, 10);
    endtask

    task automatic test_stall();
        run_op("stall_mult", 3'd1, 32'd3, 32'd5, 1'b1, 5, 32'd0, 32'd15, 5);
        @(negedge clk);
        d_is_md = 1'b0; op_valid = 1'b0; op = 3'd0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignored_op_busy got %0b want 0", busy); end
        n_cmp++; if (lo !== 32'd15) begin n_bad++; $display("FAIL ignored_op_lo got %h want 0000000f", lo); end
        run_op("nostall_mult", 3'd1, 32'd6, 32'd7, 1'b0, 2, 32'd0, 32'd42, 5);
    endtask

    task automatic test_mtlo_after();
        run_op("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'd1, 5);
        run_op("mult_big", 3'd1, 32'h4000_0000, 32'd8, 1'b0, 0, 32'd2, 32'd0, 5);
        op_valid = 1'b1; op = 3'd6; rs_data = 32'hAA;
        #1;
        n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL mtlo_start got %0b want 0", start); end
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        #1;
        n_cmp++; if (lo !== 32'hAA) begin n_bad++; $display("FAIL mtlo_lo got %h want 000000aa", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL mtlo_hi got %h want 00000002", hi); end
    endtask

    task automatic test_reset_abort();
        int n;
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; rs_data = 32'h10; rt_data = 32'h10;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            @(negedge clk);
            op_valid = 1'b0; op = 3'd0;
            if (busy) n++;
        end
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL abort_reach got %0d busy cycles want 3", n); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL abort_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL abort_lo got %h want 0", lo); end
        repeat (6) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || lo !== 32'd0) begin n_bad++; $display("FAIL abort_quiet got busy=%0b lo=%h want 0/0", busy, lo); end
        run_op("after_abort", 3'd1, 32'd3, 32'd4, 1'b0, 0, 32'd0, 32'd12, 5);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_div0();
        test_stall();
        test_mtlo_after();
        test_reset_abort();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
